// File: rtl/rst_seq_watchdog.sv
// Reset sequencer and run watchdog: staggered per-domain reset release from one
// global reset, then cycle counting, forward-progress watchdog and halt capture.
module rst_seq_watchdog #(
   parameter int unsigned NUM_RST     = 4,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned STAGGER     = 1,
   parameter int unsigned TIMEOUT     = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               soft_rst_req,
   input  logic               progress,
   input  logic               halt,
   output logic [NUM_RST-1:0] rst_out,
   output logic               seq_done,
   output logic               halted,
   output logic               timeout,
   output logic [63:0]        cycle_count
);

   localparam int unsigned LAST   = HOLD_CYCLES + (NUM_RST - 1) * STAGGER;
   localparam int unsigned SEQ_W  = $clog2(LAST + 1);
   localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_SEQ,
      ST_RUN,
      ST_HALTED,
      ST_TIMEOUT
   } state_t;

   state_t              state, state_d;
   logic [SEQ_W-1:0]    seq_cnt, seq_cnt_d;
   logic [WDOG_W-1:0]   wdog, wdog_d;
   logic [NUM_RST-1:0]  rst_out_d;
   logic                seq_done_d;
   logic                halted_d;
   logic                timeout_d;
   logic [63:0]         cycle_count_d;
   logic                expire;

   // Expiry only when the watchdog is one short of the limit and no progress arrives this cycle
   assign expire = (wdog == WDOG_W'(TIMEOUT - 1)) && !progress;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_SEQ;
         seq_cnt     <= '0;
         wdog        <= '0;
         rst_out     <= '1;
         seq_done    <= 1'b0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
      end else begin
         state       <= state_d;
         seq_cnt     <= seq_cnt_d;
         wdog        <= wdog_d;
         rst_out     <= rst_out_d;
         seq_done    <= seq_done_d;
         halted      <= halted_d;
         timeout     <= timeout_d;
         cycle_count <= cycle_count_d;
      end
   end

   always_comb begin
      state_d       = state;
      seq_cnt_d     = seq_cnt;
      wdog_d        = wdog;
      rst_out_d     = rst_out;
      seq_done_d    = seq_done;
      halted_d      = halted;
      timeout_d     = timeout;
      cycle_count_d = cycle_count;

      if (soft_rst_req) begin
         // Rerun the sequence; cycle_count and a sticky timeout survive
         state_d    = ST_SEQ;
         seq_cnt_d  = '0;
         wdog_d     = '0;
         rst_out_d  = '1;
         seq_done_d = 1'b0;
         halted_d   = 1'b0;
      end else begin
         unique case (state)
            ST_SEQ: begin
               for (int unsigned i = 0; i < NUM_RST; i++) begin
                  rst_out_d[i] = (32'(seq_cnt) < HOLD_CYCLES + i * STAGGER);
               end
               if (seq_cnt == SEQ_W'(LAST)) begin
                  state_d    = ST_RUN;
                  seq_done_d = 1'b1;
               end else begin
                  seq_cnt_d = seq_cnt + SEQ_W'(1);
               end
            end
            ST_RUN: begin
               if (!(&cycle_count)) begin
                  cycle_count_d = cycle_count + 64'd1;
               end
               if (progress) begin
                  wdog_d = '0;
               end else if (wdog != WDOG_W'(TIMEOUT - 1)) begin
                  wdog_d = wdog + WDOG_W'(1);
               end
               if (halt) begin
                  state_d  = ST_HALTED;
                  halted_d = 1'b1;
               end else if (expire) begin
                  state_d   = ST_TIMEOUT;
                  timeout_d = 1'b1;
               end
            end
            ST_HALTED,
            ST_TIMEOUT: begin
            end
            default: begin
               state_d = ST_SEQ;
            end
         endcase
      end
   end

endmodule
